// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder and its register block.
package dmem_pkg;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_STORES = 2'd1;
  localparam logic [1:0] OFF_GPIO   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int ST_MISALIGN = 0;
  localparam int ST_RANGE    = 1;

  localparam logic [15:0] MMIO_PAGE_DEFAULT = 16'hFFFF;

  typedef struct packed {
    logic is_mmio;
    logic misalign;
    logic out_of_range;
  } decode_t;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped register block: CYCLE and STORES counters, GPIO output, sticky
// W1C STATUS with set-over-clear priority, and the register read mux.
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        store_ok,
  input  logic        mmio_wr,
  input  logic [1:0]  off,
  input  logic [15:0] wr_data,
  input  logic [1:0]  err_set,
  output logic [31:0] rd_data,
  output logic [15:0] gpio_out,
  output logic        err
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stores_q, stores_d;
  logic [15:0] gpio_q, gpio_d;
  logic [1:0]  status_q, status_d;
  logic [1:0]  status_clr;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    gpio_d     = gpio_q;
    status_clr = 2'b00;
    cycle_d    = cycle_q + 32'd1;
    stores_d   = stores_q + {31'd0, store_ok};
    if (mmio_wr && off == OFF_GPIO)   gpio_d     = wr_data;
    if (mmio_wr && off == OFF_STATUS) status_clr = wr_data[1:0];
    // OR-ing the new errors in after the clear makes a same-cycle set win.
    status_d = (status_q & ~status_clr) | err_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      stores_q <= '0;
      gpio_q   <= '0;
      status_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      gpio_q   <= gpio_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (off)
      OFF_CYCLE:  rd_data = cycle_q;
      OFF_STORES: rd_data = stores_q;
      OFF_GPIO:   rd_data = {16'h0, gpio_q};
      OFF_STATUS: rd_data = {30'h0, status_q};
    endcase
  end

  assign gpio_out = gpio_q;
  assign err      = |status_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the core's MEM stage: word RAM plus MMIO register page,
// combinational loads, stores committed on the clock edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [15:0] MMIO_PAGE   = MMIO_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic [15:0] gpio_out,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  decode_t       dec;
  logic          store_ok;
  logic [1:0]    err_set;
  logic [31:0]   mmio_rd;

  assign word_idx = addr_in[AW+1:2];

  always_comb begin
    dec.is_mmio      = (addr_in[31:16] == MMIO_PAGE);
    dec.misalign     = (addr_in[1:0] != 2'b00);
    dec.out_of_range = !dec.is_mmio && (addr_in[31:AW+2] != '0);
  end

  // Faulting stores are dropped; faulting loads still flag STATUS.
  assign store_ok = mem_write && !dec.misalign && !dec.out_of_range;

  always_comb begin
    err_set              = 2'b00;
    err_set[ST_MISALIGN] = dec.misalign;
    err_set[ST_RANGE]    = dec.out_of_range;
  end

  // NOTE: the RAM array has no reset; clearing it would need a reset port on every word.
  always_ff @(posedge clk) begin
    if (!rst && store_ok && !dec.is_mmio) ram_q[word_idx] <= data_in;
  end

  dmem_mmio_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .store_ok (store_ok),
    .mmio_wr  (store_ok && dec.is_mmio),
    .off      (addr_in[3:2]),
    .wr_data  (data_in[15:0]),
    .err_set  (err_set),
    .rd_data  (mmio_rd),
    .gpio_out (gpio_out),
    .err      (err)
  );

  always_comb begin
    if (dec.is_mmio)           data_out = mmio_rd;
    else if (dec.out_of_range) data_out = 32'h0;
    else                       data_out = ram_q[word_idx];
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's data port: it answers the core's MEM-stage load and store accesses. It combines a word-organised RAM with a small memory-mapped register block. The register block holds a cycle counter, a store counter, a GPIO output and a sticky error status. Reads are combinational so the core's MEM/WB register captures load data at the end of the MEM cycle. Writes commit on the clock edge.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; must be a power of two.
- MMIO_PAGE, 16'hFFFF: value of addr_in[31:16] that selects the register block.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  one clock; reset is synchronous and active-high.
- addr_in  input  32  byte address from core (core's addr_out).
- data_in  input  32  store data from core (core's data_out).
- mem_write  input  1  store strobe; high = store this cycle; low = load/idle.
- data_out  output  32  load data to core (core's data_in); combinational.
- gpio_out  output  16  GPIO register contents.
- err  output  1  OR of STATUS bits.

## Operation
- Decode:
  - MMIO when addr_in[31:16] == MMIO_PAGE; register offset is addr_in[3:2]; addr_in[15:4] is ignored (aliases).
  - Otherwise RAM. Word index = addr_in[log2(DEPTH_WORDS)+1:2].
  - A RAM access is out-of-range when addr_in[31:log2(DEPTH_WORDS)+2] is nonzero.
- Misaligned access (addr_in[1:0] != 0):
  - A store is dropped and sets STATUS[0].
  - A load returns the aligned word and also sets STATUS[0].
- Out-of-range access:
  - A store is dropped and sets STATUS[1].
  - A load returns 32'h0 and sets STATUS[1].
- MMIO registers:
  - off 0, CYCLE: read-only. Increments by 1 every non-reset cycle and wraps 32'hFFFFFFFF→0. Writes are ignored but still counted as accepted stores.
  - off 1, STORES: read-only. Counts accepted stores (RAM or MMIO, aligned, in range) and wraps at 2^32.
  - off 2, GPIO: read/write. Bits [15:0] are stored; a read returns {16'h0, gpio}.
  - off 3, STATUS: bits [1:0]. Write-1-to-clear; reads return {30'h0, status}.
- Error checks apply to loads only when mem_write is low. The core holds addr_in at 0 when idle, so address 0 is a legal aligned RAM read.
- Simultaneous events:
  - An error set in the same cycle as a W1C to the same bit: set wins.
  - A store to STATUS that is itself misaligned is dropped, so no clear happens, and the bit sets.
- While rst is high, all stores are ignored and counters do not advance.

## Timing
- Load latency: 0 cycles. data_out is a function of current addr_in, RAM contents and register values.
- Store: RAM word or register updates at the rising edge where mem_write=1.
  - A load of the same address in the same cycle returns the old value.
  - A load in the next cycle returns the new value.
- A CYCLE read returns the pre-edge value. Two reads one cycle apart differ by exactly 1.
- Reset values:
  - CYCLE=0, STORES=0, GPIO=0, STATUS=0, err=0, gpio_out=0.
  - data_out follows the decode (RAM contents are not cleared by reset).
- Reset asserted mid-program: registers clear at that edge, and any store presented that cycle is discarded. The first non-reset edge gives CYCLE=1.
- err is registered (derived from the STATUS flops). It rises the cycle after the offending access.

## Structure
- Package dmem_pkg holds:
  - MMIO offset constants: OFF_CYCLE=2'd0, OFF_STORES=2'd1, OFF_GPIO=2'd2, OFF_STATUS=2'd3.
  - STATUS bit indices: ST_MISALIGN=0, ST_RANGE=1.
  - Default MMIO_PAGE.
- One sub-module, dmem_mmio_regs, contains:
  - The CYCLE, STORES, GPIO and STATUS registers.
  - W1C/set-priority logic and the read mux.
- The top level keeps the RAM array, address decode, error detection and the final data_out mux.

## Test plan
- Store/load RAM: store 32'hDEADBEEF to 0x10, then load 0x10 the next cycle → data_out=32'hDEADBEEF, STORES=1, err=0.
- Same-cycle read-during-write: RAM[0x20]=0x1111, store 0x2222 to 0x20 while probing data_out → 0x1111; next cycle → 0x2222.
- MMIO: write 0x0001ABCD to 0xFFFF0008 → gpio_out=16'hABCD, read returns 0x0000ABCD. Read 0xFFFF0000 on two consecutive cycles → values differ by 1. Write to CYCLE → CYCLE unchanged, STORES increments.
- Errors: store to 0x13 → RAM unchanged, STATUS=2'b01, err=1 next cycle. Load from DEPTH_WORDS*4 → data_out=0, STATUS=2'b11. Write 0x1 to 0xFFFF000C → STATUS=2'b10.
- Set-vs-clear: W1C 0x3 to STATUS at a misaligned MMIO address (0xFFFF000D) → store dropped, STATUS[0] stays/sets to 1.
- Reset mid-run: after 50 cycles with GPIO=0x00FF, assert rst for one cycle while mem_write=1 to 0x40 → CYCLE=0, STORES=0, GPIO=0, STATUS=0, RAM[0x40] unchanged. First post-reset CYCLE read=1.
